// File: rtl/intersection_phase_scheduler.sv
// Two-street intersection sequencer: green/yellow/all-red phases with sensor arbitration and a pedestrian walk phase.
// Optional night flashing mode is built when NIGHT_FLASH_EN is defined.
module intersection_phase_scheduler #(
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 12,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 6,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SA,
   input  logic       SB,
   input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
   input  logic       night,
`endif
   output logic [2:0] LA,
   output logic [2:0] LB,
   output logic       walk
);

   typedef enum logic [2:0] {
      A_GREEN, A_YELLOW, CLR_AB, B_GREEN, B_YELLOW, CLR_BA, PED_WALK
`ifdef NIGHT_FLASH_EN
      , FLASH
`endif
   } state_t;

   localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] CLR_M1  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] timer_reg;
   logic             ped_pending_reg;
   logic             last_b_reg;
   logic [2:0]       la_reg, lb_reg;
   logic             walk_reg;
   logic             night_req;
   logic             min_done;
   logic             ped_accept;
`ifdef NIGHT_FLASH_EN
   logic             flash_on_reg, flash_on_next;
`endif

   assign LA   = la_reg;
   assign LB   = lb_reg;
   assign walk = walk_reg;

`ifdef NIGHT_FLASH_EN
   assign night_req  = night;
   assign ped_accept = ped_req && (state_reg != PED_WALK) && (state_reg != FLASH);
   assign flash_on_next = (state_reg != FLASH) ? 1'b1 : !flash_on_reg;
`else
   assign night_req  = 1'b0;
   assign ped_accept = ped_req && (state_reg != PED_WALK);
`endif

   assign min_done = (timer_reg >= MIN_M1);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         A_GREEN:
            if (min_done && ((SB && !SA) || (SB && timer_reg == MAX_M1) || ped_pending_reg || night_req))
               state_next = A_YELLOW;
         A_YELLOW:
            if (timer_reg == YEL_M1) state_next = CLR_AB;
         B_GREEN:
            if (min_done && ((SA && !SB) || (SA && timer_reg == MAX_M1) || ped_pending_reg || night_req))
               state_next = B_YELLOW;
         B_YELLOW:
            if (timer_reg == YEL_M1) state_next = CLR_BA;
         CLR_AB, CLR_BA:
            if (timer_reg == CLR_M1) begin
`ifdef NIGHT_FLASH_EN
               if (night_req)            state_next = FLASH;
               else
`endif
               if (ped_pending_reg)      state_next = PED_WALK;
               else if (state_reg == CLR_AB) state_next = B_GREEN;
               else                      state_next = A_GREEN;
            end
         PED_WALK:
            // Resume with the street that did not have the last green.
            if (timer_reg == WALK_M1) state_next = last_b_reg ? A_GREEN : B_GREEN;
`ifdef NIGHT_FLASH_EN
         FLASH:
            if (!night_req) state_next = CLR_BA;
`endif
         default: state_next = A_GREEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= A_GREEN;
         timer_reg       <= '0;
         ped_pending_reg <= 1'b0;
         last_b_reg      <= 1'b0;
         la_reg          <= 3'b001;
         lb_reg          <= 3'b100;
         walk_reg        <= 1'b0;
`ifdef NIGHT_FLASH_EN
         flash_on_reg    <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         if (state_next != state_reg) timer_reg <= '0;
         else if (timer_reg != MAX_M1) timer_reg <= timer_reg + 1'b1;

         // Entering the walk phase consumes the request, even if the button is held.
         if (state_next == PED_WALK && state_reg != PED_WALK) ped_pending_reg <= 1'b0;
         else if (ped_accept)                                  ped_pending_reg <= 1'b1;

         if (state_reg == A_GREEN)      last_b_reg <= 1'b0;
         else if (state_reg == B_GREEN) last_b_reg <= 1'b1;

`ifdef NIGHT_FLASH_EN
         flash_on_reg <= flash_on_next;
`endif
         walk_reg <= (state_next == PED_WALK);
         case (state_next)
            A_GREEN:  begin la_reg <= 3'b001; lb_reg <= 3'b100; end
            A_YELLOW: begin la_reg <= 3'b010; lb_reg <= 3'b100; end
            B_GREEN:  begin la_reg <= 3'b100; lb_reg <= 3'b001; end
            B_YELLOW: begin la_reg <= 3'b100; lb_reg <= 3'b010; end
`ifdef NIGHT_FLASH_EN
            FLASH: begin
               la_reg <= (state_next != state_reg || flash_on_next) ? 3'b010 : 3'b000;
               lb_reg <= (state_next != state_reg || flash_on_next) ? 3'b100 : 3'b000;
            end
`endif
            default:  begin la_reg <= 3'b100; lb_reg <= 3'b100; end
         endcase
      end
   end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler; observed vector is {LA, LB, walk}.
module tb_intersection_phase_scheduler;

   logic       clk = 1'b0;
   logic       reset, SA, SB, ped_req;
   logic [2:0] LA, LB;
   logic       walk;
`ifdef NIGHT_FLASH_EN
   logic       night = 1'b0;
`endif

   int total  = 0;
   int passed = 0;
   int cyc    = 0;

   localparam logic [6:0] G_A = 7'b001_100_0;
   localparam logic [6:0] Y_A = 7'b010_100_0;
   localparam logic [6:0] G_B = 7'b100_001_0;
   localparam logic [6:0] Y_B = 7'b100_010_0;
   localparam logic [6:0] RED = 7'b100_100_0;
   localparam logic [6:0] WLK = 7'b100_100_1;

   intersection_phase_scheduler dut (
      .clk     (clk),
      .reset   (reset),
      .SA      (SA),
      .SB      (SB),
      .ped_req (ped_req),
`ifdef NIGHT_FLASH_EN
      .night   (night),
`endif
      .LA      (LA),
      .LB      (LB),
      .walk    (walk)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] exp);
      total++;
      assert ({LA, LB, walk} === exp) passed++;
      else $error("FAIL %s cycle %0d: observed %b required %b", tag, cyc, {LA, LB, walk}, exp);
   endtask

   task automatic run(input int n, input logic [6:0] exp, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cyc++;
         chk(tag, exp);
      end
   endtask

   initial begin
      reset = 1'b1; SA = 1'b0; SB = 1'b0; ped_req = 1'b0;
      run(20, G_A, "reset_hold");

      // Street B requests: 4 green, 2 yellow, 1 all-red, then B green.
      reset = 1'b0; SB = 1'b1;
      chk("sb_c1", G_A);
      run(3, G_A, "sb_green");
      run(2, Y_A, "sb_yellow");
      run(1, RED, "sb_clear");
      run(1, G_B, "sb_bgreen");

      // Both streets requesting: each green capped at 12 cycles.
      SA = 1'b1;
      run(11, G_B, "max_bgreen");
      run(2,  Y_B, "max_byellow");
      run(1,  RED, "max_clrba");
      run(12, G_A, "max_agreen");
      run(2,  Y_A, "max_ayellow");
      run(1,  RED, "max_clrab");
      run(1,  G_B, "max_bgreen2");

      // Back to A, then pedestrian pulse at timer=1 with no cars.
      SB = 1'b0;
      run(3, G_B, "toa_bgreen");
      run(2, Y_B, "toa_byellow");
      run(1, RED, "toa_clr");
      run(1, G_A, "toa_agreen");
      SA = 1'b0;
      run(1, G_A, "ped_t1");
      ped_req = 1'b1;
      run(1, G_A, "ped_t2");
      ped_req = 1'b0;
      run(1, G_A, "ped_t3");
      run(2, Y_A, "ped_yellow");
      run(1, RED, "ped_clr");
      run(2, WLK, "ped_walk");
      ped_req = 1'b1;
      run(1, WLK, "ped_walk_pulse");
      ped_req = 1'b0;
      run(3, WLK, "ped_walk_end");
      run(6, G_B, "ped_bgreen_held");

      // Reset during A yellow with a walk pending: pending is dropped.
      SA = 1'b1;
      run(2, Y_B, "rst_byellow");
      run(1, RED, "rst_clr");
      run(1, G_A, "rst_agreen");
      SA = 1'b0; SB = 1'b1; ped_req = 1'b1;
      run(1, G_A, "rst_ped_set");
      ped_req = 1'b0;
      run(2, G_A, "rst_agreen2");
      run(1, Y_A, "rst_ayellow");
      reset = 1'b1; SB = 1'b0;
      run(1, G_A, "rst_mid");
      reset = 1'b0;
      run(6, G_A, "rst_no_pending");

`ifdef NIGHT_FLASH_EN
      night = 1'b1;
      run(2, Y_A, "night_yellow");
      run(1, RED, "night_clr");
      run(1, 7'b010_100_0, "flash_on1");
      run(1, 7'b000_000_0, "flash_off");
      run(1, 7'b010_100_0, "flash_on2");
      night = 1'b0;
      run(1, RED, "flash_clrba");
      run(1, G_A, "flash_agreen");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
